// File: rtl/mem_access.sv
// mem_access: memory-access stage of the 64-bit RISC-V pipeline.
//
// Sits between execute and write-back. Non-memory instructions pass through
// the output registers with one cycle of latency. Loads and stores are
// latched on acceptance and issued on a req/ready data-memory port. Load data
// is lane-selected and sign/zero-extended. The stage stalls upstream while a
// transaction is outstanding.
//
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_stall                external hazard stall (freezes acceptance/outputs)
//   i_valid ... i_mem_to_reg  instruction and control from execute
//   o_mem_req/we/addr/wdata/wstrb, i_mem_ready, i_mem_rdata  memory port
//   o_alu_result ... o_mem_to_reg  registered results to write-back
//   o_misaligned           one-cycle pulse when a misaligned access is dropped
//   o_stall                stage cannot accept a new instruction
module mem_access #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_valid,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic            i_reg_write,
  input  logic            i_mem_to_reg,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [7:0]      o_mem_wstrb,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic [XLEN-1:0] o_alu_result,
  output logic [XLEN-1:0] o_mem_data,
  output logic [31:0]     o_instruction,
  output logic            o_reg_write,
  output logic            o_mem_to_reg,
  output logic            o_misaligned,
  output logic            o_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // funct3[1:0] encodes the access size for every load and store variant,
  // including 111 which behaves as a doubleword.
  function automatic logic misaligned_f(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'b00:   misaligned_f = 1'b0;
      2'b01:   misaligned_f = off[0];
      2'b10:   misaligned_f = |off[1:0];
      default: misaligned_f = |off;
    endcase
  endfunction

  function automatic logic [7:0] strb_f(input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] mask;
    case (sz)
      2'b00:   mask = 8'h01;
      2'b01:   mask = 8'h03;
      2'b10:   mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    strb_f = mask << off;
  endfunction

  function automatic logic [XLEN-1:0] wdata_f(input logic [XLEN-1:0] rs2, input logic [2:0] off);
    wdata_f = rs2 << {off, 3'b000};
  endfunction

  function automatic logic [XLEN-1:0] load_ext_f(input logic [XLEN-1:0] rdata,
                                                 input logic [2:0]      f3,
                                                 input logic [2:0]      off);
    logic [XLEN-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_ext_f = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  load_ext_f = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b010:  load_ext_f = {{(XLEN-32){sh[31]}}, sh[31:0]};
      3'b100:  load_ext_f = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  load_ext_f = {{(XLEN-16){1'b0}}, sh[15:0]};
      3'b110:  load_ext_f = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: load_ext_f = sh;
    endcase
  endfunction

  state_t state;

  logic            is_mem;
  logic            mis_addr;
  logic            accept;
  logic            accept_mem;
  logic            accept_mis;
  logic [XLEN-1:0] load_data_p0;

  // Latched transaction (stage 0: accepted, waiting for memory)
  logic [XLEN-1:0] alu_p0;
  logic [31:0]     instr_p0;
  logic            rw_p0;
  logic            m2r_p0;
  logic [2:0]      f3_p0;
  logic [2:0]      off_p0;
  logic            store_p0;

  // Completed result parked while write-back is stalled (stage 1)
  logic [XLEN-1:0] hold_data_p1;

  assign is_mem     = i_mem_read | i_mem_write;
  assign mis_addr   = misaligned_f(i_instruction[13:12], i_alu_result[2:0]);
  assign accept     = i_valid & ~i_stall & (state == IDLE);
  assign accept_mem = accept & is_mem & ~mis_addr;
  assign accept_mis = accept & is_mem & mis_addr;

  assign o_stall = (state == REQ) | (state == HOLD) |
                   ((state == IDLE) & i_valid & is_mem & ~mis_addr);

  // Stores write nothing back from memory, so their data result is zero.
  assign load_data_p0 = store_p0 ? '0 : load_ext_f(i_mem_rdata, f3_p0, off_p0);

  // ---- stage 0: transaction latch (data only, no reset needed) ----
  always_ff @(posedge i_clk) begin
    if (accept_mem) begin
      alu_p0   <= i_alu_result;
      instr_p0 <= i_instruction;
      rw_p0    <= i_reg_write;
      m2r_p0   <= i_mem_to_reg;
      f3_p0    <= i_instruction[14:12];
      off_p0   <= i_alu_result[2:0];
      store_p0 <= i_mem_write;
    end
    if ((state == REQ) && i_mem_ready && i_stall) begin
      hold_data_p1 <= load_data_p0;
    end
  end

  // ---- stage 1: FSM, memory port and write-back output registers ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_wstrb   <= 8'h00;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_alu_result  <= '0;
      o_mem_data    <= '0;
      o_instruction <= NOP;
      o_reg_write   <= 1'b0;
      o_mem_to_reg  <= 1'b0;
      o_misaligned  <= 1'b0;
    end else begin
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_stall) begin
            // Default: bubble; overridden by a non-memory accept below.
            o_alu_result  <= '0;
            o_mem_data    <= '0;
            o_instruction <= NOP;
            o_reg_write   <= 1'b0;
            o_mem_to_reg  <= 1'b0;
            if (accept_mem) begin
              state       <= REQ;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_mem_write;
              o_mem_addr  <= {i_alu_result[XLEN-1:3], 3'b000};
              o_mem_wdata <= i_mem_write ? wdata_f(i_rs2_data, i_alu_result[2:0]) : '0;
              o_mem_wstrb <= i_mem_write ? strb_f(i_instruction[13:12], i_alu_result[2:0])
                                         : 8'h00;
            end else if (accept_mis) begin
              o_misaligned <= 1'b1;
            end else if (accept) begin
              o_alu_result  <= i_alu_result;
              o_instruction <= i_instruction;
              o_reg_write   <= i_reg_write;
              o_mem_to_reg  <= i_mem_to_reg;
            end
          end
        end
        REQ: begin
          if (i_mem_ready) begin
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_wstrb <= 8'h00;
            if (!i_stall) begin
              state         <= IDLE;
              o_alu_result  <= alu_p0;
              o_mem_data    <= load_data_p0;
              o_instruction <= instr_p0;
              o_reg_write   <= rw_p0;
              o_mem_to_reg  <= m2r_p0;
            end else begin
              state <= HOLD;
            end
          end else if (!i_stall) begin
            o_alu_result  <= '0;
            o_mem_data    <= '0;
            o_instruction <= NOP;
            o_reg_write   <= 1'b0;
            o_mem_to_reg  <= 1'b0;
          end
        end
        HOLD: begin
          if (!i_stall) begin
            state         <= IDLE;
            o_alu_result  <= alu_p0;
            o_mem_data    <= hold_data_p1;
            o_instruction <= instr_p0;
            o_reg_write   <= rw_p0;
            o_mem_to_reg  <= m2r_p0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_valid;
  logic [31:0] i_instruction;
  logic [63:0] i_alu_result;
  logic [63:0] i_rs2_data;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        i_reg_write;
  logic        i_mem_to_reg;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wstrb;
  logic        i_mem_ready;
  logic [63:0] i_mem_rdata;
  logic [63:0] o_alu_result;
  logic [63:0] o_mem_data;
  logic [31:0] o_instruction;
  logic        o_reg_write;
  logic        o_mem_to_reg;
  logic        o_misaligned;
  logic        o_stall;

  int checks;
  int failures;

  mem_access #(.XLEN(64)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_stall       (i_stall),
    .i_valid       (i_valid),
    .i_instruction (i_instruction),
    .i_alu_result  (i_alu_result),
    .i_rs2_data    (i_rs2_data),
    .i_mem_read    (i_mem_read),
    .i_mem_write   (i_mem_write),
    .i_reg_write   (i_reg_write),
    .i_mem_to_reg  (i_mem_to_reg),
    .o_mem_req     (o_mem_req),
    .o_mem_we      (o_mem_we),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .o_mem_wstrb   (o_mem_wstrb),
    .i_mem_ready   (i_mem_ready),
    .i_mem_rdata   (i_mem_rdata),
    .o_alu_result  (o_alu_result),
    .o_mem_data    (o_mem_data),
    .o_instruction (o_instruction),
    .o_reg_write   (o_reg_write),
    .o_mem_to_reg  (o_mem_to_reg),
    .o_misaligned  (o_misaligned),
    .o_stall       (o_stall)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference model: byte-oriented view of the memory rules.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] f3,
                                         input logic [63:0] a);
    int n;
    int off;
    logic [63:0] v;
    n = m_size(f3);
    off = int'(a[2:0]);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) begin
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic [7:0] m_strb(input logic [2:0] f3, input logic [63:0] a);
    logic [7:0] s;
    int off;
    off = int'(a[2:0]);
    s = '0;
    for (int i = 0; i < m_size(f3); i++) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] rs2, input logic [63:0] a);
    logic [63:0] w;
    int off;
    off = int'(a[2:0]);
    w = '0;
    for (int i = off; i < 8; i++) w[8*i +: 8] = rs2[8*(i-off) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle();
    i_valid       = 1'b0;
    i_stall       = 1'b0;
    i_instruction = NOP;
    i_alu_result  = '0;
    i_rs2_data    = '0;
    i_mem_read    = 1'b0;
    i_mem_write   = 1'b0;
    i_reg_write   = 1'b0;
    i_mem_to_reg  = 1'b0;
    i_mem_ready   = 1'b0;
    i_mem_rdata   = '0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    drive_idle();
    tick();
    tick();
    checks++; if (o_mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", o_mem_req); end
    checks++; if (o_mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", o_mem_we); end
    checks++; if (o_mem_wstrb !== 8'h00) begin failures++; $display("FAIL reset_wstrb got=%h exp=00", o_mem_wstrb); end
    checks++; if (o_alu_result !== 64'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", o_alu_result); end
    checks++; if (o_mem_data !== 64'h0) begin failures++; $display("FAIL reset_mdata got=%h exp=0", o_mem_data); end
    checks++; if (o_instruction !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", o_instruction, NOP); end
    checks++; if (o_reg_write !== 1'b0 || o_mem_to_reg !== 1'b0) begin failures++; $display("FAIL reset_ctrl got rw=%0b m2r=%0b exp=0", o_reg_write, o_mem_to_reg); end
    checks++; if (o_misaligned !== 1'b0) begin failures++; $display("FAIL reset_mis got=%0b exp=0", o_misaligned); end
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", o_stall); end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    logic [63:0] a;
    logic [31:0] ins;
    logic        rw;
    logic        m2r;
    for (int i = 0; i < 8; i++) begin
      a   = (i == 0) ? 64'h1234 : rand64();
      ins = (i == 0) ? 32'h00b5_0533 : $urandom;
      rw  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      m2r = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      i_valid = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b0;
      i_alu_result = a; i_instruction = ins; i_reg_write = rw; i_mem_to_reg = m2r;
      #1;
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL alu_stall[%0d] got=%0b exp=0", i, o_stall); end
      tick();
      checks++; if (o_alu_result !== a) begin failures++; $display("FAIL alu_result[%0d] got=%h exp=%h", i, o_alu_result, a); end
      checks++; if (o_instruction !== ins) begin failures++; $display("FAIL alu_instr[%0d] got=%h exp=%h", i, o_instruction, ins); end
      checks++; if (o_reg_write !== rw || o_mem_to_reg !== m2r) begin failures++; $display("FAIL alu_ctrl[%0d] got rw=%0b m2r=%0b exp rw=%0b m2r=%0b", i, o_reg_write, o_mem_to_reg, rw, m2r); end
      checks++; if (o_mem_data !== 64'h0) begin failures++; $display("FAIL alu_mdata[%0d] got=%h exp=0", i, o_mem_data); end
    end
    drive_idle();
    tick();
    checks++; if (o_reg_write !== 1'b0 || o_mem_to_reg !== 1'b0 || o_instruction !== NOP) begin failures++; $display("FAIL alu_bubble got rw=%0b m2r=%0b instr=%h exp 0/0/%h", o_reg_write, o_mem_to_reg, o_instruction, NOP); end
  endtask

  task automatic test_load();
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [31:0] ins;
    logic        rw;
    int          d;
    for (int i = 0; i < 10; i++) begin
      f3    = (i == 0) ? 3'd0 : (i == 1) ? 3'd4 : 3'($urandom_range(0, 7));
      addr  = (i < 2) ? 64'h1003 : (rand64() & ~(64'(m_size(f3)) - 64'd1));
      rdata = (i < 2) ? 64'h0000_0000_8000_0000 : rand64();
      d     = (i < 2) ? 2 : $urandom_range(0, 3);
      rw    = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      ins   = $urandom;
      ins[14:12] = f3;
      i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
      i_alu_result = addr; i_instruction = ins; i_reg_write = rw; i_mem_to_reg = 1'b1;
      #1;
      checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL ld_accept_stall[%0d] got=%0b exp=1", i, o_stall); end
      tick();
      drive_idle();
      #1;
      checks++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b0 || o_mem_wstrb !== 8'h00) begin failures++; $display("FAIL ld_req[%0d] got req=%0b we=%0b strb=%h exp 1/0/00", i, o_mem_req, o_mem_we, o_mem_wstrb); end
      checks++; if (o_mem_addr !== {addr[63:3], 3'b000}) begin failures++; $display("FAIL ld_addr[%0d] got=%h exp=%h", i, o_mem_addr, {addr[63:3], 3'b000}); end
      checks++; if (o_reg_write !== 1'b0 || o_instruction !== NOP || o_stall !== 1'b1) begin failures++; $display("FAIL ld_bubble[%0d] got rw=%0b instr=%h stall=%0b", i, o_reg_write, o_instruction, o_stall); end
      for (int k = 0; k < d; k++) begin
        tick();
        checks++; if (o_mem_req !== 1'b1 || o_stall !== 1'b1 || o_mem_addr !== {addr[63:3], 3'b000}) begin failures++; $display("FAIL ld_wait[%0d.%0d] got req=%0b stall=%0b addr=%h", i, k, o_mem_req, o_stall, o_mem_addr); end
      end
      i_mem_ready = 1'b1; i_mem_rdata = rdata;
      tick();
      i_mem_ready = 1'b0; i_mem_rdata = '0;
      #1;
      checks++; if (o_mem_data !== m_load(rdata, f3, addr)) begin failures++; $display("FAIL ld_data[%0d] f3=%0d got=%h exp=%h", i, f3, o_mem_data, m_load(rdata, f3, addr)); end
      checks++; if (o_alu_result !== addr || o_instruction !== ins) begin failures++; $display("FAIL ld_wb[%0d] got alu=%h instr=%h exp alu=%h instr=%h", i, o_alu_result, o_instruction, addr, ins); end
      checks++; if (o_reg_write !== rw || o_mem_to_reg !== 1'b1 || o_mem_req !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL ld_done[%0d] got rw=%0b m2r=%0b req=%0b stall=%0b", i, o_reg_write, o_mem_to_reg, o_mem_req, o_stall); end
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] rs2;
    logic [31:0] ins;
    int          d;
    for (int i = 0; i < 8; i++) begin
      f3   = (i == 0) ? 3'd1 : 3'($urandom_range(0, 3));
      addr = (i == 0) ? 64'h2006 : (rand64() & ~(64'(m_size(f3)) - 64'd1));
      rs2  = (i == 0) ? 64'hABCD : rand64();
      d    = $urandom_range(0, 2);
      ins  = $urandom;
      ins[14:12] = f3;
      i_valid = 1'b1; i_mem_write = 1'b1; i_mem_read = (i % 3 == 2);
      i_alu_result = addr; i_rs2_data = rs2; i_instruction = ins;
      i_reg_write = 1'b0; i_mem_to_reg = 1'b0;
      #1;
      checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL st_accept_stall[%0d] got=%0b exp=1", i, o_stall); end
      tick();
      drive_idle();
      #1;
      checks++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1) begin failures++; $display("FAIL st_req[%0d] got req=%0b we=%0b exp 1/1", i, o_mem_req, o_mem_we); end
      checks++; if (o_mem_wstrb !== m_strb(f3, addr)) begin failures++; $display("FAIL st_wstrb[%0d] got=%h exp=%h", i, o_mem_wstrb, m_strb(f3, addr)); end
      checks++; if (o_mem_wdata !== m_wdata(rs2, addr)) begin failures++; $display("FAIL st_wdata[%0d] got=%h exp=%h", i, o_mem_wdata, m_wdata(rs2, addr)); end
      checks++; if (o_mem_addr !== {addr[63:3], 3'b000}) begin failures++; $display("FAIL st_addr[%0d] got=%h exp=%h", i, o_mem_addr, {addr[63:3], 3'b000}); end
      for (int k = 0; k < d; k++) begin
        tick();
        checks++; if (o_mem_req !== 1'b1 || o_mem_wdata !== m_wdata(rs2, addr) || o_mem_wstrb !== m_strb(f3, addr)) begin failures++; $display("FAIL st_stable[%0d.%0d] got req=%0b wdata=%h strb=%h", i, k, o_mem_req, o_mem_wdata, o_mem_wstrb); end
      end
      i_mem_ready = 1'b1; i_mem_rdata = rand64();
      tick();
      i_mem_ready = 1'b0; i_mem_rdata = '0;
      #1;
      checks++; if (o_mem_data !== 64'h0 || o_reg_write !== 1'b0 || o_alu_result !== addr || o_instruction !== ins) begin failures++; $display("FAIL st_wb[%0d] got mdata=%h rw=%0b alu=%h instr=%h", i, o_mem_data, o_reg_write, o_alu_result, o_instruction); end
      checks++; if (o_mem_req !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL st_done[%0d] got req=%0b stall=%0b exp 0/0", i, o_mem_req, o_stall); end
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] a2;
    int          s;
    for (int i = 0; i < 6; i++) begin
      f3 = (i == 0) ? 3'd2 : 3'($urandom_range(1, 3));
      if (i > 0 && f3 != 3'd3 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
      s = m_size(f3);
      addr = (i == 0) ? 64'h2002 : ((rand64() & ~64'd7) | 64'($urandom_range(1, s - 1)));
      i_valid = 1'b1; i_instruction = 32'h0000_0003 | (32'(f3) << 12);
      i_alu_result = addr; i_rs2_data = rand64();
      i_mem_read = (i % 2 == 0); i_mem_write = (i % 2 == 1);
      i_reg_write = (i % 2 == 0); i_mem_to_reg = (i % 2 == 0);
      #1;
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL mis_stall[%0d] got=%0b exp=0", i, o_stall); end
      tick();
      checks++; if (o_misaligned !== 1'b1 || o_mem_req !== 1'b0) begin failures++; $display("FAIL mis_pulse[%0d] got mis=%0b req=%0b exp 1/0", i, o_misaligned, o_mem_req); end
      checks++; if (o_reg_write !== 1'b0 || o_mem_to_reg !== 1'b0 || o_instruction !== NOP) begin failures++; $display("FAIL mis_bubble[%0d] got rw=%0b m2r=%0b instr=%h", i, o_reg_write, o_mem_to_reg, o_instruction); end
      a2 = rand64();
      i_mem_read = 1'b0; i_mem_write = 1'b0; i_alu_result = a2;
      i_instruction = 32'h0000_0033; i_reg_write = 1'b1; i_mem_to_reg = 1'b0;
      #1;
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL mis_next_stall[%0d] got=%0b exp=0", i, o_stall); end
      tick();
      checks++; if (o_misaligned !== 1'b0 || o_alu_result !== a2 || o_reg_write !== 1'b1) begin failures++; $display("FAIL mis_next[%0d] got mis=%0b alu=%h rw=%0b exp 0/%h/1", i, o_misaligned, o_alu_result, o_reg_write, a2); end
      drive_idle();
    end
  endtask

  task automatic test_stall_hold();
    logic [63:0] v1;
    logic [63:0] v2;
    logic [63:0] addr;
    logic [63:0] rdata;
    v1 = rand64(); v2 = rand64();
    i_valid = 1'b1; i_alu_result = v1; i_instruction = 32'h0000_0033; i_reg_write = 1'b1;
    tick();
    i_stall = 1'b1; i_alu_result = v2; i_reg_write = 1'b0;
    tick();
    checks++; if (o_alu_result !== v1 || o_reg_write !== 1'b1) begin failures++; $display("FAIL stall_freeze got alu=%h rw=%0b exp %h/1", o_alu_result, o_reg_write, v1); end
    i_stall = 1'b0;
    tick();
    checks++; if (o_alu_result !== v2 || o_reg_write !== 1'b0) begin failures++; $display("FAIL stall_release got alu=%h rw=%0b exp %h/0", o_alu_result, o_reg_write, v2); end
    addr  = rand64() & ~64'd7;
    rdata = rand64();
    i_valid = 1'b1; i_mem_read = 1'b1; i_instruction = 32'h0000_3003;
    i_alu_result = addr; i_reg_write = 1'b1; i_mem_to_reg = 1'b1;
    tick();
    drive_idle();
    i_stall = 1'b1;
    tick();
    checks++; if (o_mem_req !== 1'b1 || o_reg_write !== 1'b0) begin failures++; $display("FAIL stall_req_keep got req=%0b rw=%0b exp 1/0", o_mem_req, o_reg_write); end
    i_mem_ready = 1'b1; i_mem_rdata = rdata;
    tick();
    i_mem_ready = 1'b0; i_mem_rdata = '0;
    #1;
    checks++; if (o_mem_req !== 1'b0 || o_stall !== 1'b1 || o_reg_write !== 1'b0) begin failures++; $display("FAIL hold1 got req=%0b stall=%0b rw=%0b exp 0/1/0", o_mem_req, o_stall, o_reg_write); end
    tick();
    checks++; if (o_mem_req !== 1'b0 || o_stall !== 1'b1 || o_mem_data !== 64'h0) begin failures++; $display("FAIL hold2 got req=%0b stall=%0b mdata=%h exp 0/1/0", o_mem_req, o_stall, o_mem_data); end
    i_stall = 1'b0;
    tick();
    checks++; if (o_mem_data !== m_load(rdata, 3'd3, addr) || o_reg_write !== 1'b1 || o_mem_to_reg !== 1'b1 || o_alu_result !== addr) begin failures++; $display("FAIL hold_out got mdata=%h rw=%0b m2r=%0b alu=%h exp mdata=%h", o_mem_data, o_reg_write, o_mem_to_reg, o_alu_result, rdata); end
    checks++; if (o_stall !== 1'b0 || o_mem_req !== 1'b0) begin failures++; $display("FAIL hold_idle got stall=%0b req=%0b exp 0/0", o_stall, o_mem_req); end
    tick();
    checks++; if (o_mem_req !== 1'b0 || o_reg_write !== 1'b0) begin failures++; $display("FAIL hold_no_rereq got req=%0b rw=%0b exp 0/0", o_mem_req, o_reg_write); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [63:0] a2;
    addr  = rand64() & ~64'd3;
    rdata = rand64();
    a2    = rand64();
    i_valid = 1'b1; i_mem_read = 1'b1; i_instruction = 32'h0000_2003;
    i_alu_result = addr; i_reg_write = 1'b1; i_mem_to_reg = 1'b1;
    tick();
    i_mem_read = 1'b0; i_mem_to_reg = 1'b0; i_alu_result = a2; i_instruction = 32'h0000_0033;
    i_mem_ready = 1'b1; i_mem_rdata = rdata;
    #1;
    checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL b2b_req_stall got=%0b exp=1", o_stall); end
    tick();
    i_mem_ready = 1'b0; i_mem_rdata = '0;
    #1;
    checks++; if (o_mem_data !== m_load(rdata, 3'd2, addr) || o_alu_result !== addr || o_mem_to_reg !== 1'b1) begin failures++; $display("FAIL b2b_load got mdata=%h alu=%h exp mdata=%h alu=%h", o_mem_data, o_alu_result, m_load(rdata, 3'd2, addr), addr); end
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL b2b_free_stall got=%0b exp=0", o_stall); end
    tick();
    checks++; if (o_alu_result !== a2 || o_mem_to_reg !== 1'b0 || o_mem_data !== 64'h0) begin failures++; $display("FAIL b2b_alu got alu=%h m2r=%0b mdata=%h exp %h/0/0", o_alu_result, o_mem_to_reg, o_mem_data, a2); end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [63:0] addr;
    addr = rand64() & ~64'd7;
    i_valid = 1'b1; i_mem_write = 1'b1; i_instruction = 32'h0000_3023;
    i_alu_result = addr; i_rs2_data = rand64();
    tick();
    drive_idle();
    #1;
    checks++; if (o_mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_pre got req=%0b exp=1", o_mem_req); end
    i_rst_n = 1'b0;
    tick();
    checks++; if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_mem_wstrb !== 8'h00 || o_stall !== 1'b0) begin failures++; $display("FAIL rstmid_port got req=%0b we=%0b strb=%h stall=%0b", o_mem_req, o_mem_we, o_mem_wstrb, o_stall); end
    checks++; if (o_reg_write !== 1'b0 || o_instruction !== NOP || o_alu_result !== 64'h0) begin failures++; $display("FAIL rstmid_out got rw=%0b instr=%h alu=%h", o_reg_write, o_instruction, o_alu_result); end
    i_rst_n = 1'b1;
    i_mem_ready = 1'b1; i_mem_rdata = rand64();
    tick();
    i_mem_ready = 1'b0; i_mem_rdata = '0;
    #1;
    checks++; if (o_reg_write !== 1'b0 || o_mem_data !== 64'h0 || o_instruction !== NOP || o_mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_late_ready got rw=%0b mdata=%h instr=%h req=%0b", o_reg_write, o_mem_data, o_instruction, o_mem_req); end
    tick();
    checks++; if (o_alu_result !== 64'h0 || o_stall !== 1'b0) begin failures++; $display("FAIL rstmid_after got alu=%h stall=%0b exp 0/0", o_alu_result, o_stall); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_rst_n  = 1'b0;
    drive_idle();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_stall_hold();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the 64-bit RISC-V pipeline, between execute and write_back.
- Takes the executed instruction, ALU result and store data, and runs loads/stores on a req/ready data-memory port.
- Load data is byte/half/word-selected and sign- or zero-extended.
- Registers alu_result, mem_data, instruction, reg_write and mem_to_reg for the write-back stage.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- XLEN, 64, data and address width; only 64 is supported.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  synchronous active-low reset
- i_stall  input  1  external hazard stall: freezes acceptance and output registers
- i_valid  input  1  execute stage presents an instruction
- i_instruction  input  32  instruction word; funct3 = [14:12]
- i_alu_result  input  64  ALU result, or effective address for loads/stores
- i_rs2_data  input  64  store data
- i_mem_read  input  1  instruction is a load
- i_mem_write  input  1  instruction is a store
- i_reg_write  input  1  instruction writes rd
- i_mem_to_reg  input  1  rd source is memory
- o_mem_req  output  1  memory request
- o_mem_we  output  1  1 = store
- o_mem_addr  output  64  doubleword-aligned address ({addr[63:3],3'b0})
- o_mem_wdata  output  64  store data shifted into its byte lanes
- o_mem_wstrb  output  8  byte-lane enables
- i_mem_ready  input  1  memory completes the transfer this cycle
- i_mem_rdata  input  64  aligned doubleword, valid when i_mem_ready=1
- o_alu_result  output  64  registered to write-back
- o_mem_data  output  64  registered, extended load data
- o_instruction  output  32  registered instruction
- o_reg_write  output  1  registered
- o_mem_to_reg  output  1  registered
- o_misaligned  output  1  one-cycle pulse: misaligned access dropped
- o_stall  output  1  stage cannot accept a new instruction

Behaviour:
- Reset (i_rst_n=0 at a clock edge, any state, including mid-transaction):
  - state goes to IDLE; o_mem_req=0; o_mem_we=0; o_mem_wstrb=0.
  - All registered outputs go to 0; instruction register is 0x00000013 (NOP); o_misaligned=0.
  - Any in-flight transaction is abandoned; a late i_mem_ready is ignored.
- Accept: i_valid & !i_stall & state==IDLE.
- Non-memory accept: output registers load the inputs next edge (1-cycle latency); o_mem_data=0.
- IDLE with i_valid=0, or the result of a memory op not yet available: output registers load a bubble (o_reg_write=0, o_mem_to_reg=0, instruction=NOP).
- i_stall=1: output registers and state hold, except a transaction already in REQ.
- Memory accept:
  - Latch address, funct3, store data and control.
  - Go to REQ; output bubble.
- Misaligned accept (address not a multiple of access size): no request; output bubble; o_misaligned=1 for one cycle; stay IDLE.
- Sizes by funct3:
  - 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
  - 111 is treated as D.
  - Stores use the low two funct3 bits only.
- Store: o_mem_wdata = rs2 shifted left by 8*addr[2:0]; o_mem_wstrb = size mask (0x01/0x03/0x0F/0xFF) shifted left by addr[2:0].
- Load: o_mem_wstrb=0; byte-select by addr[2:0]; sign-extend for B/H/W, zero-extend for BU/HU/WU.
- REQ state:
  - o_mem_req=1; address, we, wdata and wstrb stay stable until i_mem_ready=1.
  - i_mem_ready=1 & !i_stall: outputs take the latched instruction, extended data (0 for stores) and control next edge; go to IDLE.
  - i_mem_ready=1 & i_stall: result goes to a hold buffer; go to HOLD; o_mem_req drops next cycle.
- HOLD state: no request; when i_stall=0, the buffer loads the outputs; go to IDLE.
- o_stall = (state==REQ) | (state==HOLD) | (state==IDLE & i_valid & (i_mem_read|i_mem_write) & aligned).
- Minimum load/store latency: 2 cycles (accept edge, then ready in the first REQ cycle).
- Only one outstanding transaction; i_mem_read & i_mem_write both set is treated as a store.

Test Plan:
1. ADD result 0x1234 with reg_write=1, no stall -> next edge o_alu_result=0x1234, o_reg_write=1, o_mem_to_reg=0, o_stall=0 throughout.
2. LB at addr 0x1003, rdata=0x0000_0000_8000_0000 (byte 3 = 0x80), ready on 3rd REQ cycle:
   - o_mem_req high 3 cycles, o_mem_addr=0x1000, o_stall high for the accept cycle plus 3 REQ cycles.
   - Then o_mem_data=0xFFFF_FFFF_FFFF_FF80.
   - Repeat as LBU -> 0x80.
3. SH at addr 0x2006 with rs2=0xABCD -> o_mem_wstrb=0xC0, o_mem_wdata=0xABCD_0000_0000_0000, o_mem_we=1; WB sees o_reg_write=0.
4. LW at addr 0x2002 -> no o_mem_req, o_misaligned pulse 1 cycle, bubble output, next instruction accepted the following cycle.
5. LD completes (ready=1) while i_stall=1 for 2 cycles -> outputs frozen; loaded doubleword appears the edge after i_stall drops; no second request.
6. i_rst_n=0 during REQ with i_mem_ready=0 -> next edge o_mem_req=0, state IDLE, outputs reset; ready asserted afterwards produces no write-back.
